// File: rtl/store.sv
// Hart store unit: SW as a single write, SB/SH as read-modify-write of the aligned word.
// Define STORE_RMW_EN to support SB/SH; without it only aligned SW is legal.
module store (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        enable_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] destination_i,
    input  logic [31:0] value_i,
    output logic        finished_o,
    output logic        error_o,
    input  logic        hart_to_memory_controller_ready_i,
    output logic        hart_to_memory_controller_valid_o,
    output logic [31:0] hart_to_memory_controller_address_o,
    output logic        hart_to_memory_controller_write_o,
    output logic [31:0] hart_to_memory_controller_write_data_o,
    input  logic        memory_controller_to_hart_valid_i,
    input  logic        memory_controller_to_hart_error_i,
    input  logic [31:0] memory_controller_to_hart_read_data_i,
    output logic        memory_controller_to_hart_ready_o
);

    typedef enum logic [2:0] {StIdle, StReadReq, StReadWait, StWriteReq, StWriteWait} state_e;

    state_e      state_q;
    logic        valid_q, write_q;
    logic [31:0] address_q, write_data_q;
    logic        illegal;

`ifdef STORE_RMW_EN
    logic [1:0]  offset_q;
    logic        half_q;
    logic [15:0] lane_q;
    logic [31:0] merged;

    // Byte offset 0 is the most significant lane, matching the load unit.
    always_comb begin
        merged = memory_controller_to_hart_read_data_i;
        if (half_q) begin
            if (offset_q[1]) merged[15:0] = lane_q;
            else             merged[31:16] = lane_q;
        end else begin
            case (offset_q)
                2'd0:    merged[31:24] = lane_q[7:0];
                2'd1:    merged[23:16] = lane_q[7:0];
                2'd2:    merged[15:8]  = lane_q[7:0];
                default: merged[7:0]   = lane_q[7:0];
            endcase
        end
    end

    assign illegal = (funct3_i > 3'd2) ||
                     (funct3_i == 3'd1 && destination_i[0]) ||
                     (funct3_i == 3'd2 && destination_i[1:0] != 2'b00);
`else
    logic unused_read_data;
    assign unused_read_data = ^memory_controller_to_hart_read_data_i;
    assign illegal = (funct3_i != 3'd2) || (destination_i[1:0] != 2'b00);
`endif

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= StIdle;
            valid_q      <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            write_data_q <= 32'd0;
`ifdef STORE_RMW_EN
            offset_q     <= 2'd0;
            half_q       <= 1'b0;
            lane_q       <= 16'd0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable_i && !illegal) begin
                        valid_q   <= 1'b1;
                        address_q <= {destination_i[31:2], 2'b00};
`ifdef STORE_RMW_EN
                        offset_q  <= destination_i[1:0];
                        half_q    <= funct3_i[0];
                        lane_q    <= value_i[15:0];
                        if (funct3_i != 3'd2) begin
                            write_q      <= 1'b0;
                            write_data_q <= 32'd0;
                            state_q      <= StReadReq;
                        end else
`endif
                        begin
                            write_q      <= 1'b1;
                            write_data_q <= value_i;
                            state_q      <= StWriteReq;
                        end
                    end
                end
`ifdef STORE_RMW_EN
                StReadReq: begin
                    if (hart_to_memory_controller_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StReadWait;
                    end
                end
                StReadWait: begin
                    if (memory_controller_to_hart_valid_i) begin
                        if (memory_controller_to_hart_error_i) begin
                            state_q <= StIdle;
                        end else begin
                            valid_q      <= 1'b1;
                            write_q      <= 1'b1;
                            write_data_q <= merged;
                            state_q      <= StWriteReq;
                        end
                    end
                end
`endif
                StWriteReq: begin
                    if (hart_to_memory_controller_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StWriteWait;
                    end
                end
                StWriteWait: begin
                    if (memory_controller_to_hart_valid_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        finished_o = 1'b0;
        error_o    = 1'b0;
        case (state_q)
            StIdle: begin
                finished_o = enable_i && illegal;
                error_o    = enable_i && illegal;
            end
            StReadWait: begin
                finished_o = memory_controller_to_hart_valid_i && memory_controller_to_hart_error_i;
                error_o    = memory_controller_to_hart_valid_i && memory_controller_to_hart_error_i;
            end
            StWriteWait: begin
                finished_o = memory_controller_to_hart_valid_i;
                error_o    = memory_controller_to_hart_valid_i && memory_controller_to_hart_error_i;
            end
            default: ;
        endcase
    end

    assign hart_to_memory_controller_valid_o      = valid_q;
    assign hart_to_memory_controller_address_o    = address_q;
    assign hart_to_memory_controller_write_o      = write_q;
    assign hart_to_memory_controller_write_data_o = write_data_q;
    assign memory_controller_to_hart_ready_o      = 1'b1;

endmodule

// File: tb/tb_store.sv
// Bench for store: directed table, random ops against a byte-lane reference model, and
// hand sequences for stall stability and mid-operation reset.
module tb_store;

`ifdef STORE_RMW_EN
    localparam bit Rmw = 1'b1;
`else
    localparam bit Rmw = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] destination = 32'd0, value = 32'd0;
    logic        finished, error;
    logic        req_ready = 1'b0, req_valid, req_write;
    logic [31:0] req_address, req_write_data;
    logic        rsp_valid = 1'b0, rsp_error = 1'b0, rsp_ready;
    logic [31:0] rsp_data = 32'd0;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    store dut (
        .clock                                  (clock),
        .clear_n                                (clear_n),
        .enable_i                               (enable),
        .funct3_i                               (funct3),
        .destination_i                          (destination),
        .value_i                                (value),
        .finished_o                             (finished),
        .error_o                                (error),
        .hart_to_memory_controller_ready_i      (req_ready),
        .hart_to_memory_controller_valid_o      (req_valid),
        .hart_to_memory_controller_address_o    (req_address),
        .hart_to_memory_controller_write_o      (req_write),
        .hart_to_memory_controller_write_data_o (req_write_data),
        .memory_controller_to_hart_valid_i      (rsp_valid),
        .memory_controller_to_hart_error_i      (rsp_error),
        .memory_controller_to_hart_read_data_i  (rsp_data),
        .memory_controller_to_hart_ready_o      (rsp_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          fin;
        bit          err;
        int          nrd;
        int          nwr;
        int          lat;
        int          viol;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } result_t;

    // Plays the memory controller: optional ready stalls, response one cycle after handshake.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] dest, input logic [31:0] val,
                          input logic [31:0] rd, input bit rd_err, input bit wr_err,
                          input int stall, input bit drop_en, output result_t r);
        bit          pend = 0, pend_rd = 0, pend_n, pend_rd_n = 0, stalled = 0;
        logic [31:0] p_addr = 0, p_data = 0;
        logic        p_write = 0;
        int          scnt = 0;
        r = '{default: 0};
        funct3 = f3;
        destination = dest;
        value = val;
        for (int c = 0; c < 60 && !r.fin; c++) begin
            @(negedge clock);
            enable = drop_en ? (c == 0) : 1'b1;
            rsp_valid = pend;
            rsp_error = pend ? (pend_rd ? rd_err : wr_err) : 1'b0;
            rsp_data = (pend && pend_rd) ? rd : 32'h5A5A5A5A;
            pend_n = 0;
            if (stalled && !(req_valid && req_address == p_addr && req_write == p_write &&
                             req_write_data == p_data)) r.viol++;
            stalled = 0;
            if (req_valid) begin
                if (scnt < stall) begin
                    req_ready = 0;
                    scnt++;
                    stalled = 1;
                    p_addr = req_address;
                    p_write = req_write;
                    p_data = req_write_data;
                end else begin
                    req_ready = 1;
                    scnt = 0;
                    pend_n = 1;
                    pend_rd_n = !req_write;
                    if (req_write) begin
                        r.nwr++;
                        r.waddr = req_address;
                        r.wdata = req_write_data;
                    end else begin
                        r.nrd++;
                        r.raddr = req_address;
                    end
                end
            end else begin
                req_ready = 0;
            end
            #1;
            if (finished) begin
                if (req_valid) r.viol++;
                r.fin = 1;
                r.err = error;
                r.lat = c + 1;
            end else if (error) begin
                r.viol++;
            end
            pend = pend_n;
            pend_rd = pend_rd_n;
        end
        @(negedge clock);
        enable = 0;
        req_ready = 0;
        rsp_valid = 0;
        rsp_error = 0;
    endtask

    // Reference: the word is four big-endian byte lanes; the store overwrites its lanes.
    task automatic check_op(input logic [2:0] f3, input logic [31:0] dest, input logic [31:0] val,
                            input logic [31:0] rd, input bit rd_err, input bit wr_err,
                            input int stall, input result_t r);
        bit          legal, reads, writes, exp_err;
        logic [7:0]  b[4];
        logic [31:0] exp_data;
        int          off, exp_lat;
        off = int'(dest[1:0]);
        if (f3 == 3'd2)      legal = (off == 0);
        else if (f3 == 3'd1) legal = Rmw && (off % 2 == 0);
        else if (f3 == 3'd0) legal = Rmw;
        else                 legal = 0;
        reads = legal && f3 != 3'd2;
        writes = legal && !(reads && rd_err);
        for (int i = 0; i < 4; i++) b[i] = 8'(rd >> (8 * (3 - i)));
        if (f3 == 3'd0) b[off] = val[7:0];
        if (f3 == 3'd1 && off % 2 == 0) begin
            b[off] = val[15:8];
            b[off + 1] = val[7:0];
        end
        exp_data = (f3 == 3'd2) ? val : {b[0], b[1], b[2], b[3]};
        exp_err = !legal || (reads && rd_err) || (writes && wr_err);
        if (!legal)            exp_lat = 1;
        else if (!reads)       exp_lat = 3 + stall;
        else if (rd_err)       exp_lat = 3 + stall;
        else                   exp_lat = 5 + 2 * stall;
        chk("finished_seen", 32'(r.fin), 32'(1));
        chk("error", 32'(r.err), 32'(exp_err));
        chk("read_count", r.nrd, reads ? 1 : 0);
        chk("write_count", r.nwr, writes ? 1 : 0);
        chk("latency", r.lat, exp_lat);
        chk("protocol_violations", r.viol, 0);
        if (reads) chk("read_addr", r.raddr, dest & ~32'd3);
        if (writes) begin
            chk("write_addr", r.waddr, dest & ~32'd3);
            chk("write_data", r.wdata, exp_data);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] dest;
        logic [31:0] val;
        logic [31:0] rd;
        bit          rd_err;
        int          stall;
        bit          exp_err;
        bit          exp_write;
        logic [31:0] exp_wdata;
    } vec_t;

    initial begin
        vec_t    vecs[8];
        result_t r;

        vecs[0] = '{3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF};
        vecs[1] = '{3'd0, 32'h203, 32'h000000AA, 32'h11223344, 0, 0, !Rmw, Rmw, 32'h112233AA};
        vecs[2] = '{3'd1, 32'h300, 32'h0000BEEF, 32'h11223344, 0, 0, !Rmw, Rmw, 32'hBEEF3344};
        vecs[3] = '{3'd1, 32'h301, 32'h0000BEEF, 32'h11223344, 0, 0, 1, 0, 32'h0};
        vecs[4] = '{3'd2, 32'h102, 32'h12345678, 32'h0, 0, 0, 1, 0, 32'h0};
        vecs[5] = '{3'd3, 32'h100, 32'h12345678, 32'h0, 0, 0, 1, 0, 32'h0};
        vecs[6] = '{3'd0, 32'h200, 32'h000000AA, 32'h11223344, 1, 0, 1, 0, 32'h0};
        vecs[7] = '{3'd2, 32'h400, 32'hCAFEF00D, 32'h0, 0, 4, 0, 1, 32'hCAFEF00D};

        #2;
        chk("rst_valid", 32'(req_valid), 32'(0));
        chk("rst_write", 32'(req_write), 32'(0));
        chk("rst_address", req_address, 32'h0);
        chk("rst_write_data", req_write_data, 32'h0);
        chk("rst_finished", 32'(finished), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rsp_ready_tied", 32'(rsp_ready), 32'(1));
        @(negedge clock);
        clear_n = 1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].f3, vecs[i].dest, vecs[i].val, vecs[i].rd, vecs[i].rd_err, 0,
                   vecs[i].stall, 0, r);
            chk($sformatf("tbl%0d_error", i), 32'(r.err), 32'(vecs[i].exp_err));
            chk($sformatf("tbl%0d_writes", i), r.nwr, vecs[i].exp_write ? 1 : 0);
            if (vecs[i].exp_write) chk($sformatf("tbl%0d_wdata", i), r.wdata, vecs[i].exp_wdata);
            check_op(vecs[i].f3, vecs[i].dest, vecs[i].val, vecs[i].rd, vecs[i].rd_err, 0,
                     vecs[i].stall, r);
        end

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] dest, val, rd;
            bit          rd_err, wr_err, drop;
            int          stall;
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            dest = $urandom;
            if ($urandom_range(0, 1) == 1) dest[1:0] = (f3 == 3'd1) ? {dest[1], 1'b0} : 2'b00;
            val = $urandom;
            rd = $urandom;
            rd_err = ($urandom_range(0, 7) == 0);
            wr_err = ($urandom_range(0, 7) == 0);
            stall = $urandom_range(0, 2);
            drop = $urandom_range(0, 1) == 1;
            run_op(f3, dest, val, rd, rd_err, wr_err, stall, drop, r);
            check_op(f3, dest, val, rd, rd_err, wr_err, stall, r);
        end

        // Reset while waiting for a response; the late response must be ignored.
        @(negedge clock);
        funct3 = Rmw ? 3'd0 : 3'd2;
        destination = Rmw ? 32'h203 : 32'h500;
        value = 32'h000000AA;
        enable = 1;
        @(negedge clock);
        chk("midrst_req_valid", 32'(req_valid), 32'(1));
        req_ready = 1;
        @(negedge clock);
        enable = 0;
        req_ready = 0;
        chk("midrst_handshake_done", 32'(req_valid), 32'(0));
        clear_n = 0;
        #1;
        chk("midrst_valid_low", 32'(req_valid), 32'(0));
        chk("midrst_address_zero", req_address, 32'h0);
        #1;
        clear_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            rsp_valid = (c == 0);
            rsp_data = 32'h11223344;
            #1;
            chk($sformatf("stray_rsp_finished_c%0d", c), 32'(finished), 32'(0));
            chk($sformatf("stray_rsp_valid_c%0d", c), 32'(req_valid), 32'(0));
        end
        rsp_valid = 0;

        run_op(3'd2, 32'h600, 32'h0BADF00D, 32'h0, 0, 0, 1, 0, r);
        check_op(3'd2, 32'h600, 32'h0BADF00D, 32'h0, 0, 0, 1, r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
